// File: rtl/updown_mod_counter.sv
// Up/down counter with a programmable modulus, parallel load, and wrap or saturate boundary mode.
// count, wrap and sat come from flops; count_bar and tc are combinational views of the count and inputs.
module updown_mod_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULO   = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_bar,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam int unsigned     EXT_W    = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);
  localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MODULO);
  localparam bit               SAT_MODE = (SATURATE != 0);

  // Refuse to elaborate with a modulus that the count register cannot represent.
  generate
    if ((MODULO < 2) || (64'(MODULO) > (64'd1 << WIDTH))) begin : g_bad_modulo
      $error("updown_mod_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             at_max, at_min;
  logic [EXT_W-1:0] load_ext;

  assign at_max   = (count_q == MAX_CNT);
  assign at_min   = (count_q == '0);
  assign load_ext = {1'b0, load_val};

  // Next-state: load beats count; flags are only ever set by an enabled boundary edge.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (load) begin
      count_d = (load_ext >= MOD_EXT) ? MAX_CNT : load_val;
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          count_d = count_q + WIDTH'(1);
        end else if (SAT_MODE) begin
          sat_d = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_min) begin
          count_d = count_q - WIDTH'(1);
        end else if (SAT_MODE) begin
          sat_d = 1'b1;
        end else begin
          count_d = MAX_CNT;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  // tc is left ungated by load so a cascaded stage sees the carry/borrow as soon as en and up settle.
  assign tc        = en & ((up & at_max) | (~up & at_min));
  assign count     = count_q;
  assign count_bar = ~count_q;
  assign wrap      = wrap_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: a wrap-mode and a saturate-mode instance share stimulus and
// are compared against an arithmetic reference model after every edge.
module tb_updown_mod_counter;

  localparam int unsigned W = 4;
  localparam int unsigned M = 10;

  logic                clk;
  logic                rst;
  logic                en;
  logic                up;
  logic                load;
  logic [W-1:0]        load_val;
  logic [1:0][W-1:0]   cnt;
  logic [1:0][W-1:0]   cnt_bar;
  logic [1:0]          tc;
  logic [1:0]          wrp;
  logic [1:0]          st;

  int tests;
  int fails;

  int m_cnt  [2];
  bit m_wrap [2];
  bit m_sat  [2];

  updown_mod_counter #(.WIDTH(W), .MODULO(M), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt[0]), .count_bar(cnt_bar[0]), .tc(tc[0]), .wrap(wrp[0]), .sat(st[0])
  );

  updown_mod_counter #(.WIDTH(W), .MODULO(M), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt[1]), .count_bar(cnt_bar[1]), .tc(tc[1]), .wrap(wrp[1]), .sat(st[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic model_tc(input int s);
    return en && ((up && m_cnt[s] == M - 1) || (!up && m_cnt[s] == 0));
  endfunction

  task automatic check_tc();
    for (int s = 0; s < 2; s++)
      check($sformatf("d%0d.tc_comb", s), 32'(tc[s]), 32'(model_tc(s)));
  endtask

  task automatic check_all();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("d%0d.count", s),     32'(cnt[s]),     32'(m_cnt[s]));
      check($sformatf("d%0d.count_bar", s), 32'(cnt_bar[s]), 32'((~m_cnt[s]) & 15));
      check($sformatf("d%0d.tc", s),        32'(tc[s]),      32'(model_tc(s)));
      check($sformatf("d%0d.wrap", s),      32'(wrp[s]),     32'(m_wrap[s]));
      check($sformatf("d%0d.sat", s),       32'(st[s]),      32'(m_sat[s]));
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s]  = 0;
      m_wrap[s] = 1'b0;
      m_sat[s]  = 1'b0;
    end
  endtask

  // Reference: target = count +/- 1; in range it is taken, out of range it wraps modulo M or is blocked.
  task automatic model_edge();
    int tgt;
    if (rst) begin
      model_reset();
      return;
    end
    for (int s = 0; s < 2; s++) begin
      m_wrap[s] = 1'b0;
      m_sat[s]  = 1'b0;
      if (load) begin
        m_cnt[s] = (int'(load_val) >= M) ? M - 1 : int'(load_val);
      end else if (en) begin
        tgt = up ? m_cnt[s] + 1 : m_cnt[s] - 1;
        if (tgt >= 0 && tgt < M) m_cnt[s] = tgt;
        else if (s == 0) begin
          m_cnt[s]  = (tgt + M) % M;
          m_wrap[s] = 1'b1;
        end else m_sat[s] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] lv);
    en = e; up = u; load = l; load_val = lv;
    #1;
    check_tc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    model_reset();
    #2;
    check_all();
    rst = 1'b0;

    // Count up across the top boundary.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 4'd0);
    check("wrap_dut_after_12_up", 32'(cnt[0]), 32'd2);
    check("sat_dut_held_at_max",  32'(cnt[1]), 32'd9);

    // Load 2 then count down through zero.
    step(1'b1, 1'b1, 1'b1, 4'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'd0);

    // Load 8, run into the top bound, then reverse.
    step(1'b1, 1'b1, 1'b1, 4'd8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);

    // Load priority over count, and clamping of out-of-range values.
    step(1'b1, 1'b1, 1'b1, 4'd5);
    step(1'b1, 1'b1, 1'b1, 4'd14);
    step(1'b1, 1'b0, 1'b1, 4'd10);
    step(1'b0, 1'b0, 1'b1, 4'd15);
    step(1'b1, 1'b1, 1'b1, 4'd0);

    // Enable gating and direction change mid-count.
    step(1'b1, 1'b1, 1'b1, 4'd4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    check("dir_change_final", 32'(cnt[0]), 32'd4);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)));

    // Asynchronous reset between edges at count 9, then reset dominating a load.
    step(1'b0, 1'b1, 1'b1, 4'd9);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    en = 1'b1; load = 1'b1; load_val = 4'd7;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    #2;
    rst = 1'b0; en = 1'b0; load = 1'b0;
    step(1'b1, 1'b0, 1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable and a selectable wrap or saturate mode. It is the next generation of the team's ripple JK up/down counter: a single-clock, glitch-free count value with terminal-count and wrap status, for use as a divider, event counter or address generator.

Parameters:
- WIDTH, 4, width of the count register in bits.
- MODULO, 16, number of count states; the count range is 0..MODULO-1. Legal range is 2 <= MODULO <= 2**WIDTH; elaboration fails outside this range.
- SATURATE, 0, boundary mode. 0 means the count wraps at the ends of the range. 1 means the count holds at the ends of the range.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  registered count value.
- count_bar  output  WIDTH  bitwise inverse of count, combinational.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse.
- sat  output  1  registered saturation flag.

Behaviour:
- Reset: rst=1 immediately forces count=0, wrap=0 and sat=0, with no clock needed. count_bar then reads all ones. The first update after rst deasserts is at the next rising clk edge.
- Priority on each rising edge: rst, then load, then en. If none applies, the count holds.
- Load:
  - load=1 sets count=load_val in one cycle; en and up are ignored.
  - If load_val >= MODULO, count is set to MODULO-1 (clamped).
  - A load forces wrap=0 and sat=0.
- Count, when en=1 and load=0:
  - up=1 and count<MODULO-1: count+1.
  - up=0 and count>0: count-1.
  - Arithmetic is unsigned and is never allowed to exceed MODULO-1 internally.
- Boundary, wrap mode (SATURATE=0):
  - Up at MODULO-1 goes to 0; down at 0 goes to MODULO-1.
  - wrap=1 for the single cycle after a wrap edge, otherwise 0.
  - sat stays 0.
- Boundary, saturate mode (SATURATE=1):
  - Up at MODULO-1 holds; down at 0 holds.
  - sat=1 while an enabled count is being blocked at a bound: it is set on the blocked edge and cleared on the next edge where the count moves, a load occurs, or en=0.
  - wrap stays 0.
- tc is combinational: en & ((up & count==MODULO-1) | (~up & count==0)). It may be used as a carry or borrow enable when cascading counters. load does not gate tc.
- Direction change: up may toggle on any cycle. The new direction applies on that edge with no extra latency.
- en=0: count holds, wrap=0, sat=0.
- Latency: one clock from en, up or load to count. tc has zero latency from count, en and up.
- Outputs are glitch-free; no internal clock derived from data is permitted, and all flops use clk.

Test Plan:
- Reset: assert rst mid-count at count=9 between clock edges -> count=0, wrap=0 and sat=0 with no clk edge; count_bar=4'hF.
- Wrap up, WIDTH=4, MODULO=10, SATURATE=0, en=1, up=1 for 12 cycles from 0:
  - count goes 0,1,...,9,0,1,2.
  - tc=1 only while count=9.
  - wrap=1 for exactly the one cycle in which count=0 after the 9->0 edge.
- Wrap down, MODULO=10: load 2, then up=0 for 4 cycles -> count 2,1,0,9,8; tc=1 while count=0; wrap pulses once after the 0->9 edge.
- Saturate, MODULO=10, SATURATE=1:
  - Load 8, up=1 for 4 cycles -> count 8,9,9,9; sat=1 from the first blocked edge onward.
  - Then set up=0 -> count 8 on the next edge and sat clears.
- Load priority and clamp, MODULO=10:
  - load=1, en=1, load_val=5 -> count=5 next edge with no increment.
  - load_val=14 -> count=9.
  - Simultaneous rst and load -> count=0.
- Enable gating and mid-count direction change:
  - At count=4, set en=0 for 3 cycles -> count holds at 4, tc=0, wrap=0.
  - Then en=1, up=1 for 2 cycles, then up=0 for 2 cycles -> count 5,6,5,4.
